mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between the instruction-fetch and
// data (load/store) requesters of the CPU.
//
// The grant FSM is registered and sits in IDLE between any two grants. Data
// requests have priority. A saturating starvation counter forces an
// instruction grant once STARVE_MAX data grants have completed while iREN
// was held.
//
// Ports:
//   CLK, nRST                clock (rising edge), async active-low reset
//   iREN, iaddr              instruction read request (level) and address
//   iwait, iload             instruction stall and read data
//   dREN, dWEN               data read/write requests (level)
//   daddr, dstore            data address and write data
//   dwait, dload             data stall and read data
//   ramREN, ramWEN           RAM read/write enables
//   ramaddr, ramstore        RAM address and write data
//   ramload, ramstate        RAM read data; 0=FREE 1=BUSY 2=ACCESS 3=ERROR
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  // instruction side
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [ADDR_W-1:0] iload,
  // data side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic              dwait,
  output logic [ADDR_W-1:0] dload,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0] state_q, state_d;
  logic [3:0] starve_q, starve_d;

  logic dreq;
  logic ram_access;
  logic idone;
  logic ddone;

  assign dreq       = dREN | dWEN;
  assign ram_access = (ramstate == RAM_ACCESS);

  // A grant only completes while its requester still asks for it; a dropped
  // request in a grant state is an abort and never reports done.
  assign idone = (state_q == GNT_I) & iREN & ram_access;
  assign ddone = (state_q == GNT_D) & dreq & ram_access;

  assign iwait = iREN & ~idone;
  assign dwait = dreq & ~ddone;
  assign iload = idone ? ramload : '0;
  assign dload = ddone ? ramload : '0;

  // RAM drive. Enables follow the live request level so an abort releases
  // the RAM in the same cycle. BUSY/FREE/ERROR simply keep the request up,
  // which is also how ERROR retries the access.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      GNT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
      end
      GNT_D: begin
        // write wins when both dREN and dWEN are set
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dWEN ? dstore : '0;
      end
      default: ;
    endcase
  end

  // Next state and starvation count
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (!iREN) starve_d = '0;
        if (dreq && iREN && (starve_q == STARVE_LIM)) begin
          state_d = GNT_I;
        end else if (dreq) begin
          state_d = GNT_D;
        end else if (iREN) begin
          state_d = GNT_I;
        end
      end
      GNT_I: begin
        if (!iREN || idone) state_d = IDLE;
        if (idone) starve_d = '0;
      end
      GNT_D: begin
        if (!dreq || ddone) state_d = IDLE;
        if (ddone && iREN && (starve_q != STARVE_LIM)) starve_d = starve_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle vectors of {inputs, expected outputs} are
// driven just after the rising edge, queued as expectations, and compared on
// the falling edge. Reset behaviour is checked by a hand-written sequence.
module tb_mem_arbiter;

  localparam logic [1:0] FR = 2'd0;
  localparam logic [1:0] BZ = 2'd1;
  localparam logic [1:0] AC = 2'd2;
  localparam logic [1:0] ER = 2'd3;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .STARVE_MAX(4),
    .ADDR_W    (32)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate)
  );

  typedef struct {
    int          id;
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  rs;
    logic [31:0] rload;
    logic        e_iwait;
    logic        e_dwait;
    logic        e_rren;
    logic        e_rwen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic [31:0] e_iload;
    logic [31:0] e_dload;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   vid    = 0;
  vec_t tbl[$];
  vec_t exp_q[$];
  vec_t cur;

  task automatic chk(input int id, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got %h expected %h", id, nm, act, exp);
    end
  endtask

  function automatic void add(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
    input logic [31:0] rl, input logic eiw, input logic edw, input logic err,
    input logic erw, input logic [31:0] ea, input logic [31:0] es,
    input logic [31:0] eil, input logic [31:0] edl);
    vec_t x;
    x.id = vid;
    vid++;
    x.iren = ir;     x.iaddr = ia;    x.dren = dr;     x.dwen = dw;
    x.daddr = da;    x.dstore = ds;   x.rs = rs;       x.rload = rl;
    x.e_iwait = eiw; x.e_dwait = edw; x.e_rren = err;  x.e_rwen = erw;
    x.e_addr = ea;   x.e_store = es;  x.e_iload = eil; x.e_dload = edl;
    tbl.push_back(x);
  endfunction

  // Drive one cycle of inputs and queue its expected outputs.
  task automatic drive(input vec_t x);
    iREN = x.iren;  iaddr = x.iaddr;   dREN = x.dren;    dWEN = x.dwen;
    daddr = x.daddr; dstore = x.dstore; ramstate = x.rs;  ramload = x.rload;
    exp_q.push_back(x);
    @(posedge CLK);
    #1;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) drive(tbl[i]);
    tbl.delete();
  endtask

  // Scoreboard: compare on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk(cur.id, "iwait",    {31'b0, iwait},  {31'b0, cur.e_iwait});
      chk(cur.id, "dwait",    {31'b0, dwait},  {31'b0, cur.e_dwait});
      chk(cur.id, "ramREN",   {31'b0, ramREN}, {31'b0, cur.e_rren});
      chk(cur.id, "ramWEN",   {31'b0, ramWEN}, {31'b0, cur.e_rwen});
      chk(cur.id, "ramaddr",  ramaddr,  cur.e_addr);
      chk(cur.id, "ramstore", ramstore, cur.e_store);
      chk(cur.id, "iload",    iload,    cur.e_iload);
      chk(cur.id, "dload",    dload,    cur.e_dload);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FR;
    #2;
    // in reset: waits mirror the requests, RAM idle
    chk(1000, "rst iwait",   {31'b0, iwait},  32'd1);
    chk(1000, "rst dwait",   {31'b0, dwait},  32'd1);
    chk(1000, "rst ramREN",  {31'b0, ramREN}, 32'd0);
    chk(1000, "rst ramaddr", ramaddr, 32'd0);
    iREN = 1'b0; dREN = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // single instruction fetch, ACCESS in the grant cycle
    add(H, 32'h40, L, L, 0, 0, FR, 0,            H, L, L, L, 0, 0, 0, 0);
    add(H, 32'h40, L, L, 0, 0, AC, 32'h1234,     L, L, H, L, 32'h40, 0, 32'h1234, 0);
    add(L, 32'h40, L, L, 0, 0, FR, 32'h1234,     L, L, L, L, 0, 0, 0, 0);
    // simultaneous requests: data first, then instruction
    add(H, 32'h44, H, L, 32'h100, 0, FR, 0,      H, H, L, L, 0, 0, 0, 0);
    add(H, 32'h44, H, L, 32'h100, 0, FR, 0,      H, H, H, L, 32'h100, 0, 0, 0);
    add(H, 32'h44, H, L, 32'h100, 0, AC, 32'hAAAA, H, L, H, L, 32'h100, 0, 0, 32'hAAAA);
    add(H, 32'h44, L, L, 32'h100, 0, FR, 0,      H, L, L, L, 0, 0, 0, 0);
    add(H, 32'h44, L, L, 32'h100, 0, AC, 32'hBBBB, L, L, H, L, 32'h44, 0, 32'hBBBB, 0);
    add(L, 32'h44, L, L, 32'h100, 0, FR, 0,      L, L, L, L, 0, 0, 0, 0);
    // write (with dREN) held through three BUSY cycles
    add(L, 0, H, H, 32'h200, 32'hDEADBEEF, FR, 0, L, H, L, L, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      add(L, 0, H, H, 32'h200, 32'hDEADBEEF, BZ, 0, L, H, L, H, 32'h200, 32'hDEADBEEF, 0, 0);
    add(L, 0, H, H, 32'h200, 32'hDEADBEEF, AC, 0, L, L, L, H, 32'h200, 32'hDEADBEEF, 0, 0);
    add(L, 0, L, L, 32'h200, 32'hDEADBEEF, FR, 0, L, L, L, L, 0, 0, 0, 0);
    // ERROR retry on an instruction grant
    add(H, 32'h80, L, L, 0, 0, FR, 0,            H, L, L, L, 0, 0, 0, 0);
    add(H, 32'h80, L, L, 0, 0, ER, 32'h777,      H, L, H, L, 32'h80, 0, 0, 0);
    add(H, 32'h80, L, L, 0, 0, ER, 32'h777,      H, L, H, L, 32'h80, 0, 0, 0);
    add(H, 32'h80, L, L, 0, 0, AC, 32'h999,      L, L, H, L, 32'h80, 0, 32'h999, 0);
    add(L, 32'h80, L, L, 0, 0, FR, 0,            L, L, L, L, 0, 0, 0, 0);
    // instruction abort, then data abort
    add(H, 32'h90, L, L, 0, 0, FR, 0,            H, L, L, L, 0, 0, 0, 0);
    add(H, 32'h90, L, L, 0, 0, BZ, 0,            H, L, H, L, 32'h90, 0, 0, 0);
    add(L, 32'h90, L, L, 0, 0, AC, 32'h555,      L, L, L, L, 32'h90, 0, 0, 0);
    add(L, 32'h90, L, L, 0, 0, FR, 0,            L, L, L, L, 0, 0, 0, 0);
    add(L, 0, H, L, 32'h600, 0, FR, 0,           L, H, L, L, 0, 0, 0, 0);
    add(L, 0, L, L, 32'h600, 0, AC, 32'h66,      L, L, L, L, 32'h600, 0, 0, 0);
    add(L, 0, L, L, 32'h600, 0, FR, 0,           L, L, L, L, 0, 0, 0, 0);
    // starvation: four data grants, forced fetch, counter cleared after
    for (int k = 0; k < 4; k++) begin
      add(H, 32'hC0, H, L, 32'h300 + k, 0, FR, 0,         H, H, L, L, 0, 0, 0, 0);
      add(H, 32'hC0, H, L, 32'h300 + k, 0, AC, 32'(k + 1), H, L, H, L, 32'h300 + k, 0, 0, 32'(k + 1));
    end
    add(H, 32'hC0, H, L, 32'h3FF, 0, FR, 0,       H, H, L, L, 0, 0, 0, 0);
    add(H, 32'hC0, H, L, 32'h3FF, 0, AC, 32'hF00D, L, H, H, L, 32'hC0, 0, 32'hF00D, 0);
    add(H, 32'hC0, H, L, 32'h3FF, 0, FR, 0,       H, H, L, L, 0, 0, 0, 0);
    add(H, 32'hC0, H, L, 32'h3FF, 0, AC, 32'hABC, H, L, H, L, 32'h3FF, 0, 0, 32'hABC);
    add(L, 32'hC0, L, L, 32'h3FF, 0, FR, 0,       L, L, L, L, 0, 0, 0, 0);
    run_tbl();

    // Reset mid-grant: build starve count to 3, then reset during a write
    for (int k = 0; k < 3; k++) begin
      add(H, 32'hD0, H, L, 32'h400 + k, 0, FR, 0,          H, H, L, L, 0, 0, 0, 0);
      add(H, 32'hD0, H, L, 32'h400 + k, 0, AC, 32'(k + 7), H, L, H, L, 32'h400 + k, 0, 0, 32'(k + 7));
    end
    add(H, 32'hD0, L, H, 32'h500, 32'hCAFE, FR, 0, H, H, L, L, 0, 0, 0, 0);
    add(H, 32'hD0, L, H, 32'h500, 32'hCAFE, BZ, 0, H, H, L, H, 32'h500, 32'hCAFE, 0, 0);
    run_tbl();
    #2;
    nRST = 1'b0;
    #1;
    chk(2000, "arst ramWEN",   {31'b0, ramWEN}, 32'd0);
    chk(2000, "arst ramREN",   {31'b0, ramREN}, 32'd0);
    chk(2000, "arst ramaddr",  ramaddr,  32'd0);
    chk(2000, "arst ramstore", ramstore, 32'd0);
    chk(2000, "arst dwait",    {31'b0, dwait},  32'd1);
    chk(2000, "arst iwait",    {31'b0, iwait},  32'd1);
    @(posedge CLK);
    #1;
    chk(2001, "arst hold ramWEN", {31'b0, ramWEN}, 32'd0);
    #1;
    nRST = 1'b1;
    // write re-granted; four data grants fit again, so the count was cleared
    add(H, 32'hD0, L, H, 32'h500, 32'hCAFE, FR, 0, H, H, L, L, 0, 0, 0, 0);
    add(H, 32'hD0, L, H, 32'h500, 32'hCAFE, AC, 0, H, L, L, H, 32'h500, 32'hCAFE, 0, 0);
    for (int k = 0; k < 3; k++) begin
      add(H, 32'hD0, H, L, 32'h510 + k, 0, FR, 0,             H, H, L, L, 0, 0, 0, 0);
      add(H, 32'hD0, H, L, 32'h510 + k, 0, AC, 32'(k + 32'h20), H, L, H, L, 32'h510 + k, 0, 0, 32'(k + 32'h20));
    end
    add(H, 32'hD0, H, L, 32'h520, 0, FR, 0,       H, H, L, L, 0, 0, 0, 0);
    add(H, 32'hD0, H, L, 32'h520, 0, AC, 32'h4242, L, H, H, L, 32'hD0, 0, 32'h4242, 0);
    add(L, 32'hD0, L, L, 32'h520, 0, FR, 0,       L, L, L, L, 0, 0, 0, 0);
    run_tbl();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
